game_controller: RTL
====================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICK_DIV, default 12500000: clk cycles between move opportunities (4 moves/s at 50 MHz).
REQ-002 Parameter DEBOUNCE_CYC, default 500000: cycles a synchronized key must hold a level before that level is accepted.
REQ-003 Parameter WIN_TICKS, default 8: move ticks spent in WIN before returning to IDLE.
REQ-004 clk  in  1  single system clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 KEY  in  4  raw pushbuttons, 1 = pressed; [0] right, [1] left, [2] up, [3] down.
REQ-007 frame_done  in  1  one-cycle pulse from datapath at raster wrap (x=319, y=239 -> 0,0).
REQ-008 move_ack  in  1  datapath has applied the presented move; one-cycle pulse.
REQ-009 bean_eaten  in  1  one-cycle pulse when man position equals bean position.
REQ-010 move_valid  out  1  move request to datapath.
REQ-011 move_dir  out  2  00 right, 01 left, 10 up, 11 down; valid while move_valid=1.
REQ-012 game_state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 reserved (never driven).
REQ-013 score  out  4  BCD-range score 0..9, feeds the HEX0 decoder.

Function
REQ-014 Each KEY bit SHALL pass a 2-flop synchronizer, then a per-bit debouncer: accepted level changes only after DEBOUNCE_CYC consecutive cycles of the new synchronized level.
REQ-015 Direction priority on debounced keys SHALL be KEY[0] > KEY[1] > KEY[2] > KEY[3]; none pressed = no move.
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 and wrap, producing a one-cycle tick at count TICK_DIV-1; it runs in PLAY and WIN only and is held at 0 in IDLE.
REQ-017 frame_seen flag SHALL set on frame_done and clear when a move request is issued; frame_done on the issue cycle leaves the flag set.
REQ-018 IDLE -> PLAY SHALL occur on a rising edge of any debounced key; that press SHALL NOT itself generate a move.
REQ-019 In PLAY, a request SHALL be issued on the cycle after a tick when a debounced key is held, frame_seen=1 and move_valid=0; otherwise that tick is dropped (no queuing).
REQ-020 move_valid and move_dir SHALL stay stable from issue until the cycle move_ack is sampled high; move_valid deasserts on the following edge. move_dir is latched at issue and ignores key changes while pending.
REQ-021 move_ack while move_valid=0 SHALL be ignored.
REQ-022 bean_eaten in PLAY SHALL increment score; at score=9 it SHALL instead leave score at 9 and transition to WIN.
REQ-023 bean_eaten and move_ack in the same cycle SHALL both be processed.
REQ-024 In WIN, no moves are issued; a pending request is dropped (move_valid deasserted) on WIN entry; after WIN_TICKS ticks the FSM SHALL go to IDLE with score cleared to 0.
REQ-025 bean_eaten outside PLAY SHALL be ignored.
REQ-026 Counter widths SHALL be ceil(log2(parameter)) bits; no truncation at default values.

Reset
REQ-027 reset=1 SHALL immediately force game_state=IDLE, score=0, move_valid=0, move_dir=00, all counters 0, frame_seen=0, debounced keys 0, independent of clk.
REQ-028 Reset asserted mid-handshake SHALL drop move_valid in the same cycle; no ack is expected afterward.
REQ-029 Reset deassertion SHALL be synchronized internally before the FSM leaves IDLE.

Verification (TICK_DIV=10, DEBOUNCE_CYC=4, WIN_TICKS=2)
REQ-030 Reset, press KEY[2] for 20 cycles -> state 00 -> 01 after debounce, no move_valid on that press.
REQ-031 In PLAY hold KEY[0]|KEY[3], pulse frame_done, next tick -> move_valid=1, move_dir=00; hold ack low 5 cycles -> outputs stable; ack -> move_valid=0 next edge.
REQ-032 Key held, no frame_done between ticks -> no second request until a frame_done precedes a tick.
REQ-033 KEY[1] glitch of 2 cycles -> no debounced change, no request.
REQ-034 Ten bean_eaten pulses in PLAY -> score 1..9, tenth enters WIN; 2 ticks later state 00, score 0; bean_eaten with move_ack same cycle -> both counted.
REQ-035 Assert reset while move_valid=1 -> move_valid=0, score=0, state=00 before next clk edge.

Source files
------------

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
//   Control path for the pac-man style maze game. Turns four raw pushbuttons
//   into at most one move request per tick, tracks the score and sequences
//   the IDLE -> PLAY -> WIN -> IDLE game flow.
//
// Ports
//   clk          system clock, all state on its rising edge
//   reset        asynchronous, active-high
//   KEY[3:0]     raw buttons, 1 = pressed ([0] right, [1] left, [2] up, [3] down)
//   frame_done   one-cycle pulse at raster wrap
//   move_ack     one-cycle pulse: datapath has applied the presented move
//   bean_eaten   one-cycle pulse: man is on the bean
//   move_valid   move request to datapath, held until acknowledged
//   move_dir     00 right, 01 left, 10 up, 11 down (valid with move_valid)
//   game_state   00 IDLE, 01 PLAY, 10 WIN
//   score        0..9
// -----------------------------------------------------------------------------

// Per-key synchronizer + debouncer. The accepted level only moves after the
// synchronized input has held the new level for DEBOUNCE_CYC straight cycles.
module game_controller_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_db
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            key_db <= 1'b0;
        end else begin
            sync <= {sync[0], key_raw};
            if (sync[1] != key_db) begin
                // cnt counts completed cycles at the new level; the
                // DEBOUNCE_CYC-th one commits it.
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    key_db <= sync[1];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module game_controller #(
    parameter int TICK_DIV     = 12500000,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int WIN_TICKS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic       frame_done,
    input  logic       move_ack,
    input  logic       bean_eaten,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [1:0] game_state,
    output logic [3:0] score
);
    localparam int NUM_KEYS = 4;
    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int WW = (WIN_TICKS > 1) ? $clog2(WIN_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WIN  = 2'b10
    } state_t;

    state_t                state, state_nxt;
    logic [NUM_KEYS-1:0]   key_db, key_db_q;
    logic                  key_rise, key_any;
    logic [1:0]            dir_sel;
    logic [1:0]            rst_pipe;
    logic                  rst_ready;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [WW-1:0]         win_cnt;
    logic                  frame_seen;
    logic                  start_hold;
    logic                  issue, score_inc, win_entry, win_done;

    // ---------------------------------------------------------------- keys
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        game_controller_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk     (clk),
            .reset   (reset),
            .key_raw (KEY[i]),
            .key_db  (key_db[i])
        );
    end

    assign key_rise = |(key_db & ~key_db_q);
    assign key_any  = |key_db;

    // Lowest index wins: right > left > up > down.
    always_comb begin
        dir_sel = 2'b00;
        if      (key_db[0]) dir_sel = 2'b00;
        else if (key_db[1]) dir_sel = 2'b01;
        else if (key_db[2]) dir_sel = 2'b10;
        else if (key_db[3]) dir_sel = 2'b11;
    end

    // Reset release is re-timed to clk; the FSM may only leave IDLE once
    // the release has propagated through both stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_pipe <= 2'b00;
        else       rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_ready = rst_pipe[1];

    assign tick = (state != S_IDLE) && (tick_cnt == TW'(TICK_DIV - 1));

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        score_inc = 1'b0;
        win_entry = 1'b0;
        win_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_rise && rst_ready) state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (bean_eaten) begin
                    if (score == 4'd9) begin
                        state_nxt = S_WIN;
                        win_entry = 1'b1;
                    end else begin
                        score_inc = 1'b1;
                    end
                end
                // Ticks without a held key, an unseen frame, or a pending
                // request are simply lost. start_hold keeps the press that
                // started the game from also moving the man.
                if (!win_entry && tick && key_any && frame_seen &&
                    !move_valid && !start_hold)
                    issue = 1'b1;
            end
            S_WIN: begin
                if (tick && win_cnt == WW'(WIN_TICKS - 1)) begin
                    state_nxt = S_IDLE;
                    win_done  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_db_q   <= '0;
            tick_cnt   <= '0;
            win_cnt    <= '0;
            frame_seen <= 1'b0;
            start_hold <= 1'b0;
            move_valid <= 1'b0;
            move_dir   <= 2'b00;
            score      <= 4'd0;
        end else begin
            key_db_q <= key_db;

            if (state == S_IDLE || tick_cnt == TW'(TICK_DIV - 1))
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            if (state != S_WIN || win_done) win_cnt <= '0;
            else if (tick)                  win_cnt <= win_cnt + 1'b1;

            // A frame arriving on the issue cycle belongs to the next move.
            if (frame_done) frame_seen <= 1'b1;
            else if (issue) frame_seen <= 1'b0;

            // Held from game start until every key is released.
            if (state == S_IDLE && state_nxt == S_PLAY) start_hold <= 1'b1;
            else if (!key_any)                          start_hold <= 1'b0;

            if (issue) begin
                move_valid <= 1'b1;
                move_dir   <= dir_sel;
            end else if (win_entry || (move_valid && move_ack)) begin
                move_valid <= 1'b0;
            end

            if (score_inc)     score <= score + 4'd1;
            else if (win_done) score <= 4'd0;
        end
    end

    assign game_state = state;
endmodule
